// File: rtl/rr_mux_4_1_stage.sv
// Registered 4:1 round-robin selection stage (valid/ready in, valid/ready out).
// Define RR_GRANT_CNT_EN to add saturating per-source grant counters on grant_cnt.
module rr_mux_4_1_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
`ifdef RR_GRANT_CNT_EN
  ,
  output logic [31:0]      grant_cnt
`endif
);

  logic [1:0]       ptr;
  logic [1:0]       gnt;
  logic             gnt_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = ~out_valid | out_ready;
  assign xfer    = load_en & gnt_vld;

  // Search starts just past the last grant, so that index ranks last.
  always_comb begin : arb
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = ptr;
    idx     = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    gnt_data = d0;
    unique case (gnt)
      2'd0: gnt_data = d0;
      2'd1: gnt_data = d1;
      2'd2: gnt_data = d2;
      2'd3: gnt_data = d3;
    endcase
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && xfer)
      in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd3;
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt;
        ptr       <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_GRANT_CNT_EN
  logic [7:0] cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        cnt[i] <= 8'd0;
    end else if (xfer && cnt[gnt] != 8'hff) begin
      cnt[gnt] <= cnt[gnt] + 8'd1;
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule
